// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage pipeline interlock controller.
// Detects RAW hazards that operand forwarding cannot resolve and stalls ID
// (freeze IF/ID, bubble into EXE). Freezes the whole pipeline while data
// memory is busy. Tracks run/stall/wait state and a sticky stall watchdog.
// Optional build macro: PERF_CNT_EN enables the stall/wait performance
// counters. Without it, stall_cnt and wait_cnt read as zero.
module hazard_stall_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic             id_valid,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_busy,
  output logic             freeze_if,
  output logic             freeze_id,
  output logic             bubble_exe,
  output logic             freeze_all,
  output logic [1:0]       state,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam logic [1:0] RUN   = 2'b00;
  localparam logic [1:0] STALL = 2'b01;
  localparam logic [1:0] WAIT  = 2'b10;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  logic            m_exe;
  logic            m_mem;
  logic            hazard;
  logic            stall_now;
  logic [1:0]      cur_state;
  logic [1:0]      next_state;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_next;

  // Source/destination match terms and hazard decision for the ID instruction.
  always_comb begin
    m_exe  = exe_wb_en && ((exe_dest == src1) || (two_src && (exe_dest == src2)));
    m_mem  = mem_wb_en && ((mem_dest == src1) || (two_src && (mem_dest == src2)));
    if (forward_en) begin
      // With forwarding only a load in EXE cannot supply its result in time.
      hazard = id_valid && m_exe && exe_mem_r_en;
    end else begin
      hazard = id_valid && (m_exe || m_mem);
    end
  end

  // Same-cycle control outputs; memory freeze dominates, and reset forces all low.
  always_comb begin
    if (!rst) begin
      freeze_all = 1'b0;
      stall_now  = 1'b0;
    end else begin
      freeze_all = mem_busy;
      stall_now  = hazard && !mem_busy;
    end
    freeze_if  = stall_now;
    freeze_id  = stall_now;
    bubble_exe = stall_now;
  end

  // Next-state priority: memory wait, then hazard stall, else run.
  always_comb begin
    if (mem_busy) begin
      next_state = WAIT;
    end else if (hazard) begin
      next_state = STALL;
    end else begin
      next_state = RUN;
    end
  end

  // Watchdog count for the coming edge: clears on RUN, saturates at TIMEOUT.
  always_comb begin
    case (next_state)
      STALL, WAIT: begin
        if (to_cnt >= TO_MAX) begin
          to_cnt_next = TO_MAX;
        end else begin
          to_cnt_next = to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end
      default: to_cnt_next = {TO_W{1'b0}};
    endcase
  end

  // State register, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_state   <= RUN;
      to_cnt      <= {TO_W{1'b0}};
      timeout_err <= 1'b0;
    end else begin
      cur_state   <= next_state;
      to_cnt      <= to_cnt_next;
      timeout_err <= timeout_err || (to_cnt_next == TO_MAX);
    end
  end

  assign state = cur_state;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_acc;
  logic [CNT_W-1:0] wait_acc;

  // Saturating counts of bubble cycles and memory-freeze cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_acc <= {CNT_W{1'b0}};
      wait_acc  <= {CNT_W{1'b0}};
    end else begin
      if (bubble_exe && (stall_acc != {CNT_W{1'b1}})) begin
        stall_acc <= stall_acc + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_acc <= stall_acc;
      end
      if (freeze_all && (wait_acc != {CNT_W{1'b1}})) begin
        wait_acc <= wait_acc + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        wait_acc <= wait_acc;
      end
    end
  end

  assign stall_cnt = stall_acc;
  assign wait_cnt  = wait_acc;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign wait_cnt  = {CNT_W{1'b0}};
`endif

endmodule
